// File: rtl/uart_rx_if.sv
// Receiver-to-FIFO write port: one byte plus its error qualifiers per wr_en strobe.
// The master drives the byte side; the FIFO reports back when it cannot accept.
interface uart_rx_if;
   logic [7:0] data_out;
   logic       wr_en;
   logic       overrun_err;
   logic       frame_err;
   logic       parity_err;
   logic       fifo_full;

   // wr_en is a one-clk strobe with no back-pressure; fifo_full is consulted at the
   // stop-bit sample, and a byte arriving while it is high is dropped and reported
   // via overrun_err on the next accepted byte.
   modport master (
      output data_out, wr_en, overrun_err, frame_err, parity_err,
      input  fifo_full
   );
   modport slave (
      input  data_out, wr_en, overrun_err, frame_err, parity_err,
      output fifo_full
   );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit mid-sampling, optional parity, and
// drop-with-overrun-flag when the downstream FIFO is full.
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_tick,
   input  logic       rx,
   uart_rx_if.master  fifo,
   output logic       busy,
   output logic [2:0] dbg_state
);
   localparam int            TW        = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic          ODD       = (PARITY_ODD != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state_q;
   logic          rx_meta_q, rx_s_q;
   logic [TW-1:0] tick_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          par_err_q, armed_q, ovr_pend_q;
   logic [7:0]    data_q;
   logic          wr_en_q, ovr_q, frame_q, parity_q;
   logic          par_err_d, frame_err_d;

   assign par_err_d   = ((^shift_q) ^ rx_s_q) != ODD;
   assign frame_err_d = ~rx_s_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         state_q    <= IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_err_q  <= 1'b0;
         armed_q    <= 1'b0;
         ovr_pend_q <= 1'b0;
         data_q     <= '0;
         wr_en_q    <= 1'b0;
         ovr_q      <= 1'b0;
         frame_q    <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         wr_en_q   <= 1'b0;
         if (baud_tick) begin
            if (rx_s_q) armed_q <= 1'b1;
            case (state_q)
               IDLE: begin
                  if (!rx_s_q && armed_q) begin
                     state_q <= START;
                     tick_q  <= '0;
                  end
               end
               START: begin
                  if (tick_q == HALF_TICK) begin
                     tick_q  <= '0;
                     bit_q   <= '0;
                     shift_q <= '0;
                     state_q <= rx_s_q ? IDLE : DATA;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               DATA: begin
                  if (tick_q == LAST_TICK) begin
                     tick_q          <= '0;
                     shift_q[bit_q]  <= rx_s_q;
                     if (bit_q == LAST_BIT) begin
                        bit_q   <= '0;
                        state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                     end else begin
                        bit_q <= bit_q + 1'b1;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               PARITY: begin
                  if (tick_q == LAST_TICK) begin
                     tick_q    <= '0;
                     par_err_q <= par_err_d;
                     state_q   <= STOP;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               STOP: begin
                  if (tick_q == LAST_TICK) begin
                     tick_q  <= '0;
                     state_q <= IDLE;
                     // A low stop sample means break or garbage: require idle-high before re-arming.
                     if (!rx_s_q) armed_q <= 1'b0;
                     if (fifo.fifo_full) begin
                        ovr_pend_q <= 1'b1;
                     end else begin
                        wr_en_q    <= 1'b1;
                        data_q     <= shift_q;
                        frame_q    <= frame_err_d;
                        parity_q   <= par_err_q;
                        ovr_q      <= ovr_pend_q;
                        ovr_pend_q <= 1'b0;
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign fifo.data_out    = data_q;
   assign fifo.wr_en       = wr_en_q;
   assign fifo.overrun_err = ovr_q;
   assign fifo.frame_err   = frame_q;
   assign fifo.parity_err  = parity_q;
   assign busy             = (state_q != IDLE);
   assign dbg_state        = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a default instance and an even-parity instance, checked against
// hand-written vectors, corner sequences and a randomized frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int OS       = 16;
   localparam int TICK_DIV = 2;
   localparam int BIT_CLKS = OS * TICK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic baud_tick = 1'b0;
   logic tick_en = 1'b1;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;
   logic busy_a, busy_b;
   logic [2:0] st_a, st_b;

   uart_rx_if if_a ();
   uart_rx_if if_b ();

   uart_rx u_dut_a (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_a),
      .fifo(if_a), .busy(busy_a), .dbg_state(st_a)
   );
   uart_rx #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_b),
      .fifo(if_b), .busy(busy_b), .dbg_state(st_b)
   );

   // ---------------- clock / reset / tick ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      int div;
      div = 0;
      forever begin
         @(negedge clk);
         div = (div + 1) % TICK_DIV;
         baud_tick = tick_en && (div == 0);
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [10:0] exp_a_q[$];
   logic [10:0] exp_b_q[$];
   logic [7:0]  last_a = 8'h00;
   logic [7:0]  last_b = 8'h00;
   logic        pend_a = 1'b0;
   logic        pend_b = 1'b0;
   int          stop_cyc_a = 0;
   int          stop_cyc_b = 0;
   logic        prev_a = 1'b0;
   logic        prev_b = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endfunction

   // Record layout: {overrun_err, parity_err, frame_err, data_out}.
   function automatic void score(input bit sel, input string pfx, input logic [10:0] got,
                                 input logic prev, input int dly);
      logic [10:0] req;
      int          n;
      check({pfx, "_single_pulse"}, 32'(prev), 32'd0);
      check({pfx, "_wr_mid_stop"}, 32'(dly >= 12 && dly <= 28), 32'd1);
      n = sel ? exp_b_q.size() : exp_a_q.size();
      if (n == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_unexpected_write actual=0x%0h required=none", pfx, got);
      end else begin
         if (sel) req = exp_b_q.pop_front();
         else     req = exp_a_q.pop_front();
         check({pfx, "_record"}, 32'(got), 32'(req));
      end
   endfunction

   initial forever begin
      @(negedge clk);
      if (rst && if_a.wr_en)
         score(1'b0, "a", {if_a.overrun_err, if_a.parity_err, if_a.frame_err, if_a.data_out},
               prev_a, cyc - stop_cyc_a);
      prev_a = if_a.wr_en;
   end

   initial forever begin
      @(negedge clk);
      if (rst && if_b.wr_en)
         score(1'b1, "b", {if_b.overrun_err, if_b.parity_err, if_b.frame_err, if_b.data_out},
               prev_b, cyc - stop_cyc_b);
      prev_b = if_b.wr_en;
   end

   // ---------------- reference model ----------------
   // Frame-level rules: drop on full (remember it), otherwise emit byte with stop/parity
   // errors and the remembered drop, which is then forgotten.
   task automatic model_frame(input bit sel, input logic [7:0] data, input logic par_bit,
                              input logic stop_bit, input logic full);
      logic pe;
      pe = sel ? logic'((($countones(data) + int'(par_bit)) % 2) != 0) : 1'b0;
      if (sel) begin
         if (full) pend_b = 1'b1;
         else begin
            exp_b_q.push_back({pend_b, pe, ~stop_bit, data});
            last_b = data;
            pend_b = 1'b0;
         end
      end else begin
         if (full) pend_a = 1'b1;
         else begin
            exp_a_q.push_back({pend_a, pe, ~stop_bit, data});
            last_a = data;
            pend_a = 1'b0;
         end
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive_bit(input bit sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] data, input logic par_bit,
                             input logic stop_bit);
      drive_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
      if (sel) drive_bit(sel, par_bit);
      if (sel) stop_cyc_b = cyc;
      else     stop_cyc_a = cyc;
      drive_bit(sel, stop_bit);
   endtask

   task automatic idle_bits(input int n);
      rx_a = 1'b1;
      rx_b = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   task automatic check_after(input bit sel, input string pfx);
      if (sel) begin
         check({pfx, "_no_missing_write"}, 32'(exp_b_q.size()), 32'd0);
         check({pfx, "_busy_idle"}, 32'(busy_b), 32'd0);
         check({pfx, "_data_hold"}, 32'(if_b.data_out), 32'(last_b));
      end else begin
         check({pfx, "_no_missing_write"}, 32'(exp_a_q.size()), 32'd0);
         check({pfx, "_busy_idle"}, 32'(busy_a), 32'd0);
         check({pfx, "_data_hold"}, 32'(if_a.data_out), 32'(last_a));
      end
   endtask

   task automatic check_reset(input string pfx, input logic [7:0] d, input logic w,
                              input logic o, input logic f, input logic p, input logic b);
      check({pfx, "_rst_data_out"}, 32'(d), 32'd0);
      check({pfx, "_rst_wr_en"}, 32'(w), 32'd0);
      check({pfx, "_rst_overrun"}, 32'(o), 32'd0);
      check({pfx, "_rst_frame_err"}, 32'(f), 32'd0);
      check({pfx, "_rst_parity_err"}, 32'(p), 32'd0);
      check({pfx, "_rst_busy"}, 32'(b), 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string      name;
      bit         sel;
      logic [7:0] data;
      logic       par_bit;
      logic       stop_bit;
      logic       full;
      bit         exp_wr;
      logic       exp_fe;
      logic       exp_pe;
      logic       exp_ovr;
   } vec_t;

   vec_t vec_q[$];

   task automatic add_vec(input string name, input bit sel, input logic [7:0] data,
                          input logic par_bit, input logic stop_bit, input logic full,
                          input bit exp_wr, input logic exp_fe, input logic exp_pe,
                          input logic exp_ovr);
      vec_t v;
      v.name = name; v.sel = sel; v.data = data; v.par_bit = par_bit;
      v.stop_bit = stop_bit; v.full = full; v.exp_wr = exp_wr;
      v.exp_fe = exp_fe; v.exp_pe = exp_pe; v.exp_ovr = exp_ovr;
      vec_q.push_back(v);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      if_a.fifo_full = 1'b0;
      if_b.fifo_full = 1'b0;

      //            name            sel data   par stop full wr  fe  pe  ovr
      add_vec("a_a5_ok",        0, 8'hA5, 0, 1, 0, 1, 0, 0, 0);
      add_vec("a_3c_bad_stop",  0, 8'h3C, 0, 0, 0, 1, 1, 0, 0);
      add_vec("a_11_dropped",   0, 8'h11, 0, 1, 1, 0, 0, 0, 0);
      add_vec("a_22_overrun",   0, 8'h22, 0, 1, 0, 1, 0, 0, 1);
      add_vec("a_33_clean",     0, 8'h33, 0, 1, 0, 1, 0, 0, 0);
      add_vec("a_00",           0, 8'h00, 0, 1, 0, 1, 0, 0, 0);
      add_vec("a_ff",           0, 8'hFF, 0, 1, 0, 1, 0, 0, 0);
      add_vec("b_07_par0",      1, 8'h07, 0, 1, 0, 1, 0, 1, 0);
      add_vec("b_07_par1",      1, 8'h07, 1, 1, 0, 1, 0, 0, 0);
      add_vec("b_00_par0",      1, 8'h00, 0, 1, 0, 1, 0, 0, 0);
      add_vec("b_c3_par1",      1, 8'hC3, 1, 1, 0, 1, 0, 1, 0);
      add_vec("b_81_bad_stop",  1, 8'h81, 0, 0, 0, 1, 1, 0, 0);
      add_vec("b_01_dropped",   1, 8'h01, 1, 1, 1, 0, 0, 0, 0);
      add_vec("b_02_overrun",   1, 8'h02, 1, 1, 0, 1, 0, 0, 1);

      repeat (6) @(negedge clk);
      check_reset("a", if_a.data_out, if_a.wr_en, if_a.overrun_err, if_a.frame_err,
                  if_a.parity_err, busy_a);
      check_reset("b", if_b.data_out, if_b.wr_en, if_b.overrun_err, if_b.frame_err,
                  if_b.parity_err, busy_b);
      rst = 1'b1;
      idle_bits(2);

      foreach (vec_q[i]) begin
         if (vec_q[i].sel) if_b.fifo_full = vec_q[i].full;
         else              if_a.fifo_full = vec_q[i].full;
         if (vec_q[i].exp_wr) begin
            if (vec_q[i].sel) begin
               exp_b_q.push_back({vec_q[i].exp_ovr, vec_q[i].exp_pe, vec_q[i].exp_fe, vec_q[i].data});
               last_b = vec_q[i].data;
            end else begin
               exp_a_q.push_back({vec_q[i].exp_ovr, vec_q[i].exp_pe, vec_q[i].exp_fe, vec_q[i].data});
               last_a = vec_q[i].data;
            end
         end
         send_frame(vec_q[i].sel, vec_q[i].data, vec_q[i].par_bit, vec_q[i].stop_bit);
         idle_bits(2);
         if_a.fifo_full = 1'b0;
         if_b.fifo_full = 1'b0;
         check_after(vec_q[i].sel, vec_q[i].name);
      end

      // False start: low for 4 ticks only.
      rx_a = 1'b0;
      repeat (4 * TICK_DIV) @(negedge clk);
      check("a_false_start_busy", 32'(busy_a), 32'd1);
      idle_bits(2);
      check_after(1'b0, "a_false_start");

      // Bad stop followed by a held-low line: nothing may start until rx returns high.
      exp_a_q.push_back({1'b0, 1'b0, 1'b1, 8'h3C});
      last_a = 8'h3C;
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
      rx_a = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      check("a_break_not_started", 32'(busy_a), 32'd0);
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("a_break_still_idle", 32'(busy_a), 32'd0);
      idle_bits(2);
      check_after(1'b0, "a_break");
      exp_a_q.push_back({1'b0, 1'b0, 1'b0, 8'h81});
      last_a = 8'h81;
      send_frame(1'b0, 8'h81, 1'b0, 1'b1);
      idle_bits(2);
      check_after(1'b0, "a_after_break");

      // Reset in the middle of the 4th data bit of 0xFF.
      rx_a = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx_a = 1'b1;
         repeat (BIT_CLKS) @(negedge clk);
      end
      repeat (BIT_CLKS / 2) @(negedge clk);
      check("a_mid_frame_busy", 32'(busy_a), 32'd1);
      rst = 1'b0;
      tick_en = 1'b0;
      rx_a = 1'b0;
      repeat (4) @(negedge clk);
      check_reset("a_mid", if_a.data_out, if_a.wr_en, if_a.overrun_err, if_a.frame_err,
                  if_a.parity_err, busy_a);
      last_a = 8'h00;
      last_b = 8'h00;
      pend_a = 1'b0;
      pend_b = 1'b0;
      rst = 1'b1;
      repeat (6) @(negedge clk);
      tick_en = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("a_unarmed_after_reset", 32'(busy_a), 32'd0);
      check("a_no_write_after_abort", 32'(if_a.data_out), 32'd0);
      idle_bits(2);
      exp_a_q.push_back({1'b0, 1'b0, 1'b0, 8'h5A});
      last_a = 8'h5A;
      send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
      idle_bits(2);
      check_after(1'b0, "a_5a_after_reset");

      // Randomized frames against the frame-level model.
      for (int n = 0; n < 26; n++) begin
         bit         sel;
         logic [7:0] data;
         logic       par_bit, stop_bit, full;
         sel      = (n >= 16);
         data     = 8'($urandom_range(0, 255));
         par_bit  = 1'($urandom_range(0, 1));
         stop_bit = ($urandom_range(0, 5) != 0);
         full     = ($urandom_range(0, 4) == 0);
         if (sel) if_b.fifo_full = full;
         else     if_a.fifo_full = full;
         model_frame(sel, data, par_bit, stop_bit, full);
         send_frame(sel, data, par_bit, stop_bit);
         idle_bits(2);
         if_a.fifo_full = 1'b0;
         if_b.fifo_full = 1'b0;
         check_after(sel, sel ? "b_rand" : "a_rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: baud_tick pulses per bit period; even, >= 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; range 5..8.
REQ-003 Parameter PARITY_EN, default 0: 1 = one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-008 rx  input  1  asynchronous serial line; idles high.
REQ-009 fifo_full  input  1  full flag from the downstream receive FIFO.
REQ-010 data_out  output  8  received byte, LSB-aligned, unused upper bits 0; feeds the FIFO data_in.
REQ-011 wr_en  output  1  one-clk write strobe; feeds the FIFO en.
REQ-012 overrun_err  output  1  qualifies data_out while wr_en=1; feeds the FIFO overrun_err.
REQ-013 frame_err  output  1  stop-bit error flag for the current data_out.
REQ-014 parity_err  output  1  parity error flag for the current data_out; always 0 when PARITY_EN=0.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value rx_s.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a tick counter (0..OVERSAMPLE-1) and a bit counter (0..DATA_BITS-1) SHALL advance only on baud_tick.
REQ-018 IDLE: on baud_tick with rx_s=0 and line_armed=1, go to START and clear the tick counter; line_armed SHALL set on any baud_tick with rx_s=1.
REQ-019 START: on the baud_tick where tick count reaches OVERSAMPLE/2-1, rx_s=0 goes to DATA with counters cleared; rx_s=1 is a false start and returns to IDLE with no output.
REQ-020 DATA: every OVERSAMPLE-th tick, rx_s SHALL be shifted in LSB first; after DATA_BITS samples go to PARITY if PARITY_EN=1, else STOP.
REQ-021 PARITY: sample one bit after OVERSAMPLE ticks; parity_err = (XOR of data bits XOR sample) != PARITY_ODD.
REQ-022 STOP: sample after OVERSAMPLE ticks; frame_err = ~sample; go to IDLE; line_armed SHALL clear when sample=0 (break/garbage must return high before the next start).
REQ-023 On the stop sample tick with fifo_full=0, wr_en SHALL pulse high for exactly one clk in the following cycle, with data_out, frame_err, parity_err and overrun_err valid in that same cycle.
REQ-024 On the stop sample tick with fifo_full=1, the byte SHALL be dropped (wr_en stays 0) and the sticky flag ovr_pend SHALL be set.
REQ-025 overrun_err SHALL equal ovr_pend during the next emitted wr_en; ovr_pend clears in that cycle; multiple drops collapse into one flag.
REQ-026 data_out and the error flags SHALL hold their values until the next wr_en pulse.
REQ-027 busy=0 and the counters cleared SHALL hold in IDLE; baud_tick=0 SHALL freeze all counters and the FSM.

Reset
REQ-028 While rst=0: FSM=IDLE, counters=0, synchronizer flops=1, line_armed=0, ovr_pend=0, data_out=0, wr_en=0, overrun_err=0, frame_err=0, parity_err=0, busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no wr_en; after release, no frame is accepted until a baud_tick sees rx_s=1.

Verification
REQ-030 Defaults, frame 0xA5 with valid stop -> one wr_en pulse, data_out=0xA5, all error flags 0, wr_en one clk after the stop mid-sample.
REQ-031 Defaults, rx low for 4 ticks then high -> false start, no wr_en, busy returns to 0.
REQ-032 Defaults, frame 0x3C with stop bit 0 -> wr_en with data_out=0x3C and frame_err=1; a following start is ignored until rx is high.
REQ-033 fifo_full=1 during frame 0x11, then 0 for frame 0x22 -> no write for 0x11; write 0x22 with overrun_err=1; next frame 0x33 has overrun_err=0.
REQ-034 PARITY_EN=1, PARITY_ODD=0, frame 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-035 rst driven low at the 4th data bit of 0xFF -> no wr_en; all outputs at reset values; the next clean frame 0x5A is received correctly.
